serial_adder: RTL and testbench
===============================

// Module: serial_adder
// PURPOSE
//  Bit-serial WIDTH-bit adder built around one instance of the fulladd cell.
//  Operands are loaded in parallel and fed LSB-first to the cell, one bit per
//  clock, with the carry held in a register between bits. Sits upstream of
//  fulladd (it drives a, b, ci) and downstream of it (it captures s, co).
//  This is the area-minimal alternative to a WIDTH-cell ripple adder.
// PARAMETERS
//  WIDTH  8  operand/sum width in bits; legal range WIDTH >= 1
// PORTS
//  clk    in   1      single clock; all state changes on rising edge
//  rst    in   1      synchronous, active-high reset
//  start  in   1      request; sampled only in IDLE
//  a      in   WIDTH  operand A; captured on accepted start
//  b      in   WIDTH  operand B; captured on accepted start
//  cin    in   1      carry-in; captured on accepted start
//  busy   out  1      high in RUN and DONE; start is ignored while high
//  done   out  1      one-cycle pulse; sum/cout valid while high
//  sum    out  WIDTH  result (a+b+cin) mod 2^WIDTH
//  cout   out  1      carry out of bit WIDTH-1
// BEHAVIOUR
//  - Interface: one clock (clk); reset (rst) is synchronous and active-high.
//  - rst=1 at an edge overrides everything: state->IDLE; a_sr, b_sr, sum_sr,
//    carry and count cleared; busy=0, done=0, sum=0, cout=0 afterwards.
//  - Datapath: a_sr, b_sr, sum_sr (WIDTH each); carry (1); count of width
//    $clog2(WIDTH+1). fulladd inputs: a=a_sr[0], b=b_sr[0], ci=carry.
//  - FSM (Moore): IDLE, RUN, DONE.
//   IDLE: start=1 -> a_sr<=a, b_sr<=b, carry<=cin, sum_sr<=0, count<=0, ->RUN.
//         start=0 -> hold all registers (sum/cout keep the last result).
//   RUN:  every edge: sum_sr<={s, sum_sr[WIDTH-1:1]}; a_sr>>=1; b_sr>>=1;
//         carry<=co; count<=count+1. When count==WIDTH-1 at the edge -> DONE.
//   DONE: held for exactly one cycle; next edge -> IDLE unconditionally.
//  - Outputs: sum=sum_sr, cout=carry, busy=(state!=IDLE), done=(state==DONE).
//  - Latency: start accepted at edge k -> WIDTH bit-steps at edges k+1..k+WIDTH
//    -> done high during the cycle after edge k+WIDTH (sampled at edge
//    k+WIDTH+1). Throughput: one operation per WIDTH+2 cycles.
//  - sum/cout are guaranteed only while done=1 and in IDLE afterwards until
//    the next accepted start. During RUN they show partial values.
//  - start in RUN or DONE is ignored (no queueing). start held high
//    continuously gives back-to-back operations, each re-sampling a/b/cin in IDLE.
//  - a/b/cin changes after the accepting edge do not affect the result.
//  - WIDTH=1: RUN lasts one cycle; done is high in the second cycle after start.
//  - rst during RUN/DONE aborts: no done pulse, outputs zeroed per rst rule.
// TESTING
//  1 Reset: rst=1 for 2 cycles with start=1 -> busy=0, done=0, sum=0, cout=0.
//  2 WIDTH=8, a=8'h3C, b=8'h05, cin=0, 1-cycle start -> done exactly at edge
//    start+9, sum=8'h41, cout=0. busy high for 9 cycles.
//  3 Carry chain: a=8'hFF, b=8'h01, cin=0 -> sum=8'h00, cout=1.
//    a=8'hFF, b=8'hFF, cin=1 -> sum=8'hFF, cout=1.
//  4 Ignore and hold: pulse start with different operands in RUN and in DONE
//    -> ignored. After done, change a/b with start=0 -> sum/cout unchanged.
//    start held high -> done pulses every 10 cycles, each result correct.
//  5 Abort: rst=1 at the 4th RUN edge -> next cycle IDLE, all outputs 0, no
//    done. Then a=8'h80, b=8'h80, cin=1 -> sum=8'h01, cout=1.
//  6 Random: 1000 ops vs. golden {cout,sum}=a+b+cin for WIDTH=8, 1 and 16.

Source files
------------

// File: rtl/serial_adder.sv
// Bit-serial adder: one full-adder cell stepped LSB-first over WIDTH clocks,
// with the inter-bit carry held in a register.

// Single-bit full adder cell used by the serial datapath.
module fulladd (
    input  logic a,
    input  logic b,
    input  logic ci,
    output logic s,
    output logic co
);

    assign s  = a ^ b ^ ci;
    assign co = (a & b) | (ci & (a ^ b));

endmodule

module serial_adder #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);

    localparam int unsigned CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;

    logic [WIDTH-1:0] r_a_sr;
    logic [WIDTH-1:0] r_b_sr;
    logic [WIDTH-1:0] r_sum_sr;
    logic             r_carry;
    logic [CW-1:0]    r_count;
    logic             r_busy;
    logic             r_done;

    logic [WIDTH-1:0] w_a_nxt;
    logic [WIDTH-1:0] w_b_nxt;
    logic [WIDTH-1:0] w_sum_nxt;
    logic [WIDTH-1:0] w_sum_shift;
    logic             w_carry_nxt;
    logic [CW-1:0]    w_count_nxt;
    logic             w_s;
    logic             w_co;

    // The single shared adder cell sees the current LSBs and the held carry.
    fulladd u_fa (
        .a  (r_a_sr[0]),
        .b  (r_b_sr[0]),
        .ci (r_carry),
        .s  (w_s),
        .co (w_co)
    );

    // New sum bit enters at the MSB so the LSB lands at bit 0 after WIDTH steps.
    generate
        if (WIDTH == 1) begin : g_w1
            assign w_sum_shift = w_s;
        end else begin : g_wn
            assign w_sum_shift = {w_s, r_sum_sr[WIDTH-1:1]};
        end
    endgenerate

    // Next-state and datapath update; registers hold unless the FSM steps them.
    always_comb begin
        w_state_nxt = r_state;
        w_a_nxt     = r_a_sr;
        w_b_nxt     = r_b_sr;
        w_sum_nxt   = r_sum_sr;
        w_carry_nxt = r_carry;
        w_count_nxt = r_count;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_a_nxt     = a;
                    w_b_nxt     = b;
                    w_carry_nxt = cin;
                    w_sum_nxt   = '0;
                    w_count_nxt = '0;
                    w_state_nxt = S_RUN;
                end
            end
            S_RUN: begin
                w_sum_nxt   = w_sum_shift;
                w_a_nxt     = r_a_sr >> 1;
                w_b_nxt     = r_b_sr >> 1;
                w_carry_nxt = w_co;
                w_count_nxt = r_count + CW'(1);
                if (r_count == CW'(WIDTH - 1)) begin
                    w_state_nxt = S_DONE;
                end
            end
            S_DONE: begin
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // State and datapath registers; busy/done are registered decodes of next state.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= S_IDLE;
            r_a_sr   <= '0;
            r_b_sr   <= '0;
            r_sum_sr <= '0;
            r_carry  <= 1'b0;
            r_count  <= '0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_a_sr   <= w_a_nxt;
            r_b_sr   <= w_b_nxt;
            r_sum_sr <= w_sum_nxt;
            r_carry  <= w_carry_nxt;
            r_count  <= w_count_nxt;
            r_busy   <= (w_state_nxt != S_IDLE);
            r_done   <= (w_state_nxt == S_DONE);
        end
    end

    assign sum  = r_sum_sr;
    assign cout = r_carry;
    assign busy = r_busy;
    assign done = r_done;

endmodule

// File: tb/tb_serial_adder.sv
// Self-checking bench for serial_adder at WIDTH = 8, 1 and 16.
module tb_serial_adder;

    logic clk = 1'b0;
    logic rst;

    logic        st8, ci8, bz8, dn8, co8;
    logic [7:0]  a8, b8, sm8;
    logic        st1, ci1, bz1, dn1, co1;
    logic [0:0]  a1, b1, sm1;
    logic        st16, ci16, bz16, dn16, co16;
    logic [15:0] a16, b16, sm16;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    serial_adder #(.WIDTH(8)) u8 (
        .clk(clk), .rst(rst), .start(st8), .a(a8), .b(b8), .cin(ci8),
        .busy(bz8), .done(dn8), .sum(sm8), .cout(co8)
    );
    serial_adder #(.WIDTH(1)) u1 (
        .clk(clk), .rst(rst), .start(st1), .a(a1), .b(b1), .cin(ci1),
        .busy(bz1), .done(dn1), .sum(sm1), .cout(co1)
    );
    serial_adder #(.WIDTH(16)) u16 (
        .clk(clk), .rst(rst), .start(st16), .a(a16), .b(b16), .cin(ci16),
        .busy(bz16), .done(dn16), .sum(sm16), .cout(co16)
    );

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic       ci;
        logic [7:0] s;
        logic       co;
    } vec_t;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic drive(input int w, input logic st, input logic [15:0] a, input logic [15:0] b,
                         input logic ci);
        case (w)
            1:       begin st1 = st;  a1 = a[0:0];  b1 = b[0:0];  ci1 = ci;  end
            8:       begin st8 = st;  a8 = a[7:0];  b8 = b[7:0];  ci8 = ci;  end
            default: begin st16 = st; a16 = a;      b16 = b;      ci16 = ci; end
        endcase
    endtask

    task automatic sample(input int w, output logic bz, output logic dn,
                          output logic [15:0] sm, output logic co);
        case (w)
            1:       begin bz = bz1;  dn = dn1;  sm = {15'd0, sm1}; co = co1;  end
            8:       begin bz = bz8;  dn = dn8;  sm = {8'd0, sm8};  co = co8;  end
            default: begin bz = bz16; dn = dn16; sm = sm16;         co = co16; end
        endcase
    endtask

    // Reference: plain integer addition, truncated to w bits, carry is bit w.
    function automatic logic [16:0] golden(input int w, input logic [15:0] a,
                                           input logic [15:0] b, input logic ci);
        logic [16:0] t;
        logic [15:0] m;
        t = 17'(a) + 17'(b) + 17'(ci);
        m = 16'((32'd1 << w) - 32'd1);
        return {t[w], t[15:0] & m};
    endfunction

    // One operation from IDLE; returns result, done latency after accept (-1 on timeout).
    task automatic do_op(input int w, input logic [15:0] a, input logic [15:0] b, input logic ci,
                         output logic [15:0] sm, output logic co, output int lat);
        logic bz, dn;
        drive(w, 1'b1, a, b, ci);
        tick();
        drive(w, 1'b0, ~a, ~b, ~ci);
        lat = -1;
        sm  = '0;
        co  = 1'b0;
        for (int i = 1; i <= w + 4; i++) begin
            tick();
            sample(w, bz, dn, sm, co);
            if (dn) begin
                lat = i;
                break;
            end
        end
        tick();
    endtask

    task automatic check_op(input string nm, input int w, input logic [15:0] a,
                            input logic [15:0] b, input logic ci);
        logic [15:0] sm;
        logic        co;
        int          lat;
        logic [16:0] g;
        g = golden(w, a, b, ci);
        do_op(w, a, b, ci, sm, co, lat);
        chk({nm, "_lat"}, 32'(lat), 32'(w));
        chk({nm, "_sum"}, 32'(sm), 32'(g[15:0]));
        chk({nm, "_cout"}, 32'(co), 32'(g[16]));
    endtask

    initial begin
        vec_t        tbl[7];
        logic        bz, dn, co, any_done;
        logic [15:0] sm, m;
        int          t, t_prev, busy_cnt, lat;
        logic [16:0] g;
        logic [7:0]  ba[3];
        logic [7:0]  bb[3];
        logic        bc[3];

        tbl[0] = '{8'h3C, 8'h05, 1'b0, 8'h41, 1'b0};
        tbl[1] = '{8'hFF, 8'h01, 1'b0, 8'h00, 1'b1};
        tbl[2] = '{8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1};
        tbl[3] = '{8'h80, 8'h80, 1'b1, 8'h01, 1'b1};
        tbl[4] = '{8'h00, 8'h00, 1'b0, 8'h00, 1'b0};
        tbl[5] = '{8'h00, 8'h00, 1'b1, 8'h01, 1'b0};
        tbl[6] = '{8'hAA, 8'h55, 1'b1, 8'h00, 1'b1};

        // Reset with start asserted.
        rst = 1'b1;
        drive(8, 1'b1, 16'h00FF, 16'h00FF, 1'b1);
        drive(1, 1'b1, 16'h1, 16'h1, 1'b1);
        drive(16, 1'b1, 16'hFFFF, 16'hFFFF, 1'b1);
        tick();
        tick();
        foreach (ba[i]) begin
            int w;
            w = (i == 0) ? 8 : (i == 1) ? 1 : 16;
            sample(w, bz, dn, sm, co);
            chk($sformatf("reset_w%0d", w), {13'd0, bz, dn, co, sm}, 32'd0);
        end
        rst = 1'b0;
        drive(8, 1'b0, 16'h0, 16'h0, 1'b0);
        drive(1, 1'b0, 16'h0, 16'h0, 1'b0);
        drive(16, 1'b0, 16'h0, 16'h0, 1'b0);
        tick();

        // Latency and busy length for a single 8-bit operation.
        drive(8, 1'b1, 16'h3C, 16'h05, 1'b0);
        tick();
        drive(8, 1'b0, 16'h00, 16'h00, 1'b0);
        busy_cnt = 1;
        lat = -1;
        for (int i = 1; i <= 14; i++) begin
            sample(8, bz, dn, sm, co);
            if (i > 1 && bz) busy_cnt++;
            if (dn && lat < 0) begin
                lat = i - 1;
                chk("lat_sum", 32'(sm), 32'h41);
                chk("lat_cout", 32'(co), 32'd0);
            end
            tick();
        end
        chk("lat_done_edge", 32'(lat), 32'd8);
        chk("lat_busy_cycles", 32'(busy_cnt), 32'd9);

        // Directed vectors.
        foreach (tbl[i]) begin
            do_op(8, 16'(tbl[i].a), 16'(tbl[i].b), tbl[i].ci, sm, co, lat);
            chk($sformatf("tbl%0d_sum", i), 32'(sm), 32'(tbl[i].s));
            chk($sformatf("tbl%0d_cout", i), 32'(co), 32'(tbl[i].co));
            chk($sformatf("tbl%0d_lat", i), 32'(lat), 32'd8);
        end

        // start pulses in RUN and DONE are ignored; result then holds in IDLE.
        drive(8, 1'b1, 16'h12, 16'h34, 1'b0);
        tick();
        drive(8, 1'b0, 16'h0, 16'h0, 1'b0);
        tick(); tick(); tick();
        drive(8, 1'b1, 16'hFF, 16'hFF, 1'b1);
        tick();
        drive(8, 1'b0, 16'h0, 16'h0, 1'b0);
        dn = 1'b0;
        for (int i = 0; i < 10 && !dn; i++) begin
            sample(8, bz, dn, sm, co);
            if (!dn) tick();
        end
        chk("ign_done_seen", 32'(dn), 32'd1);
        drive(8, 1'b1, 16'h77, 16'h77, 1'b1);
        tick();
        drive(8, 1'b0, 16'h55, 16'h66, 1'b1);
        sample(8, bz, dn, sm, co);
        chk("ign_idle_busy", 32'(bz), 32'd0);
        chk("ign_sum", 32'(sm), 32'h46);
        chk("ign_cout", 32'(co), 32'd0);
        for (int i = 0; i < 5; i++) tick();
        sample(8, bz, dn, sm, co);
        chk("hold_busy", 32'(bz), 32'd0);
        chk("hold_sum", 32'(sm), 32'h46);
        chk("hold_cout", 32'(co), 32'd0);

        // start held high: back-to-back ops every WIDTH+2 cycles.
        ba = '{8'h10, 8'hF0, 8'hC3};
        bb = '{8'h20, 8'h10, 8'h3C};
        bc = '{1'b1, 1'b0, 1'b1};
        drive(8, 1'b1, 16'(ba[0]), 16'(bb[0]), bc[0]);
        t = 0;
        t_prev = 0;
        for (int k = 0; k < 3; k++) begin
            dn = 1'b0;
            while (!dn && t < 40) begin
                tick();
                t++;
                sample(8, bz, dn, sm, co);
            end
            g = golden(8, 16'(ba[k]), 16'(bb[k]), bc[k]);
            chk($sformatf("b2b%0d_done", k), 32'(dn), 32'd1);
            chk($sformatf("b2b%0d_sum", k), 32'(sm), 32'(g[15:0]));
            chk($sformatf("b2b%0d_cout", k), 32'(co), 32'(g[16]));
            chk($sformatf("b2b%0d_time", k), 32'(t - t_prev), (k == 0) ? 32'd9 : 32'd10);
            t_prev = t;
            if (k < 2) drive(8, 1'b1, 16'(ba[k+1]), 16'(bb[k+1]), bc[k+1]);
        end
        drive(8, 1'b0, 16'h0, 16'h0, 1'b0);
        tick();
        tick();

        // Abort with reset on the 4th RUN edge.
        drive(8, 1'b1, 16'h0F, 16'h0F, 1'b0);
        tick();
        drive(8, 1'b0, 16'h0, 16'h0, 1'b0);
        tick(); tick(); tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        sample(8, bz, dn, sm, co);
        chk("abort_outputs", {13'd0, bz, dn, co, sm}, 32'd0);
        any_done = 1'b0;
        for (int i = 0; i < 12; i++) begin
            tick();
            sample(8, bz, dn, sm, co);
            any_done |= dn | bz;
        end
        chk("abort_no_done", 32'(any_done), 32'd0);
        check_op("post_abort", 8, 16'h80, 16'h80, 1'b1);

        // Random operations against the arithmetic reference.
        foreach (ba[j]) begin
            int w;
            w = (j == 0) ? 8 : (j == 1) ? 1 : 16;
            m = 16'((32'd1 << w) - 32'd1);
            for (int i = 0; i < 1000; i++) begin
                check_op($sformatf("rnd_w%0d_%0d", w, i), w, 16'($urandom) & m,
                         16'($urandom) & m, 1'($urandom));
            end
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
